truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Self-checking sweep controller for a small combinational circuit. On `start` it steps the shared input bus through every input vector in ascending order, waits a programmable settle time, and samples the circuit output. Each sample is compared against a parameterised expected truth table, and the block reports mismatch count, first failing vector and pass/fail. It sits between a bench or host and one combinational circuit such as a 2-input AND, and it is the only driver of that circuit's inputs.

## Interface
Parameters:
- `N_IN`, 2: number of circuit inputs. Legal range 1..8.
- `SETTLE`, 1: hold cycles after a vector is applied before sampling. Legal range 0..15.
- `EXP_TT`, 4'b1000: expected output. Bit `i` is the expected value for input vector `i`. Width is 2**N_IN.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `areset_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: begin a sweep. Sampled only in IDLE.
- `abort`, in, 1: cancel the sweep in progress.
- `vec_out`, out, N_IN: input vector driven to the circuit. Bit 0 is the LSB input.
- `dut_q`, in, 1: circuit output.
- `busy`, out, 1: high from the cycle after `start` is accepted until the sweep ends.
- `done`, out, 1: one-cycle pulse at the end of a completed sweep.
- `pass`, out, 1: result of the last completed sweep. 1 means zero mismatches.
- `err_count`, out, N_IN+1: number of mismatching vectors.
- `first_err_valid`, out, 1: at least one mismatch has been recorded.
- `first_err_idx`, out, N_IN: lowest vector index that mismatched.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE with `start`=1 and `abort`=0:
  - go to SETTLE;
  - `vec_out` := 0, settle counter := 0;
  - clear `err_count`, `first_err_valid`, `first_err_idx`;
  - `pass` := 0.
- SETTLE:
  - holds `vec_out` for SETTLE cycles, then goes to SAMPLE;
  - with SETTLE=0 the state is skipped and the transition goes straight to SAMPLE.
- SAMPLE, exactly one cycle:
  - mismatch is `dut_q` !== `EXP_TT[vec_out]`; X or Z on `dut_q` counts as a mismatch;
  - on mismatch, increment `err_count`;
  - if `first_err_valid`=0, also set `first_err_valid` and `first_err_idx` := `vec_out`;
  - if `vec_out` = 2**N_IN-1, go to FINISH;
  - otherwise `vec_out` += 1 and go to SETTLE, or straight to SAMPLE if SETTLE=0.
- FINISH, one cycle:
  - `done`=1;
  - `pass` := (final `err_count` == 0);
  - go to IDLE.
- Result outputs hold their values until the next accepted `start`.
- `abort` in any non-IDLE state:
  - next state is IDLE, with no `done` and no `pass` update;
  - counters keep their partial values;
  - `vec_out` returns to 0.
- `abort` takes priority over a SAMPLE update in the same cycle, so that sample is discarded.
- `start` while busy is ignored. `start` and `abort` together in IDLE: stay in IDLE.
- `err_count` cannot overflow because its width is N_IN+1, which holds at most 2**N_IN. No saturation logic.

## Timing
- Reset (asynchronous assert, release synchronous to `clk`) forces:
  - state = IDLE;
  - `vec_out`=0, `busy`=0, `done`=0, `pass`=0;
  - `err_count`=0, `first_err_valid`=0, `first_err_idx`=0.
- Reset mid-sweep: immediate return to the reset values. No `done` pulse.
- Cycle 0: `start` sampled. Cycle 1: `busy`=1, `vec_out`=0.
- Each vector occupies SETTLE+1 cycles, and `dut_q` is sampled at the last of them.
- `done` asserts at cycle 2**N_IN × (SETTLE+1) + 1. `busy` deasserts in the same cycle.
- `pass` and `err_count` are valid in the `done` cycle and all cycles after it.
- `vec_out` is registered and changes only on clock edges. `dut_q` must be stable SETTLE cycles after `vec_out` changes.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Package `truth_table_sweeper_pkg` contains:
  - the state enum type;
  - the SETTLE counter width constant (4 bits);
  - the function `exp_bit(tt, idx)`.
- Sub-module `settle_timer`: a down-counter that loads SETTLE and flags expiry, so the zero-SETTLE bypass is isolated in one place.
- Everything else lives in the top FSM with registered outputs.

## Test plan
- Correct circuit: N_IN=2, SETTLE=1, EXP_TT=4'b1000, `dut_q` = AND of the two `vec_out` bits. Start the sweep. Require:
  - `vec_out` sequence 0,1,2,3, each held 2 cycles;
  - `done` at cycle 9;
  - `pass`=1, `err_count`=0, `first_err_valid`=0.
- Wrong circuit: same parameters with `dut_q` = OR of the two `vec_out` bits. Require `err_count`=2, `first_err_idx`=1, `first_err_valid`=1, `pass`=0.
- Zero settle: SETTLE=0 with an AND circuit. Require `vec_out` to advance every cycle and `done` at cycle 5.
- Unknown output: force `dut_q`=X at vector 3. Require `err_count`=1, `first_err_idx`=3.
- Abort: assert `abort` in the SAMPLE cycle of vector 2. Require:
  - IDLE next cycle, no `done`, `pass` unchanged;
  - a fresh `start` clears the counters and completes normally.
- Reset mid-sweep: drop `areset_n` for 1 cycle while `vec_out`=1. Require all outputs at their reset values immediately, and `start` during the sweep ignored.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_pkg
//   Shared types and helpers for the truth-table sweeper.
//   - state_e   : sweep FSM states
//   - SETTLE_W  : width of the settle down-counter
//   - MAX_TT_W  : widest truth table (N_IN = 8 -> 256 entries)
//   - exp_bit() : expected-output lookup into a zero-extended truth table
// -----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_e;

    localparam int SETTLE_W = 4;
    localparam int MAX_TT_W = 256;

    // Callers zero-extend their table to MAX_TT_W so one function serves any N_IN.
    function automatic logic exp_bit(input logic [MAX_TT_W-1:0] tt,
                                     input logic [7:0]          idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   Down-counter that times how long a vector is held before sampling.
//   Loading on entry to the settle phase makes o_expired rise after exactly
//   SETTLE cycles in that phase. SETTLE = 0 is reported through o_skip so the
//   FSM can bypass the settle phase entirely.
// Ports:
//   clk, areset_n : clock, async active-low reset
//   i_load        : reload the counter (entering the settle phase)
//   i_run         : count down (currently in the settle phase)
//   o_expired     : last settle cycle; leave for the sample phase
//   o_skip        : SETTLE is zero, settle phase must not be entered
// -----------------------------------------------------------------------------
module settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic areset_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired,
    output logic o_skip
);

    // Load SETTLE-1: the cycle that sees zero is itself the last settle cycle.
    localparam logic [SETTLE_W-1:0] LOAD_VAL =
        (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);

    logic [SETTLE_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);
    assign o_skip    = (SETTLE == 0);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//   Drives every input vector of a small combinational circuit in ascending
//   order, waits SETTLE cycles, samples the circuit output and compares it with
//   the expected truth table EXP_TT (bit i = expected output for vector i).
// Ports:
//   clk, areset_n   : clock, async active-low reset
//   start           : begin a sweep (IDLE only, ignored together with abort)
//   abort           : cancel the sweep; partial counts kept, vec_out -> 0
//   vec_out         : registered vector driven to the circuit
//   dut_q           : circuit output; X/Z counts as a mismatch
//   busy            : sweep in progress
//   done            : one-cycle pulse when a sweep completes
//   pass            : last completed sweep had zero mismatches
//   err_count       : number of mismatching vectors
//   first_err_valid : at least one mismatch recorded
//   first_err_idx   : lowest mismatching vector
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = 1,
    parameter logic [(1 << N_IN)-1:0]  EXP_TT = 4'b1000
) (
    input  logic            clk,
    input  logic            areset_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_q,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_idx
);

    state_e          r_state;
    state_e          w_state_next;
    logic [N_IN-1:0] r_vec;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_err_count;
    logic            r_first_valid;
    logic [N_IN-1:0] r_first_idx;

    logic            w_expired;
    logic            w_skip;
    logic            w_timer_load;
    logic            w_last_vec;
    logic            w_exp;
    logic            w_mismatch;
    logic [N_IN:0]   w_err_after;
    state_e          w_vec_entry;

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk       (clk),
        .areset_n  (areset_n),
        .i_load    (w_timer_load),
        .i_run     (r_state == ST_SETTLE),
        .o_expired (w_expired),
        .o_skip    (w_skip)
    );

    assign w_last_vec  = &r_vec;
    assign w_exp       = exp_bit(MAX_TT_W'(EXP_TT), 8'(r_vec));
    // Case inequality so an X or Z from the circuit is never taken as a match.
    assign w_mismatch  = (dut_q !== w_exp);
    assign w_err_after = r_err_count + {{N_IN{1'b0}}, w_mismatch};
    // Every new vector starts in SETTLE, unless the settle phase is empty.
    assign w_vec_entry = w_skip ? ST_SAMPLE : ST_SETTLE;
    assign w_timer_load = (w_state_next == ST_SETTLE) && (r_state != ST_SETTLE);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) w_state_next = w_vec_entry;
            end
            ST_SETTLE: begin
                if (abort)          w_state_next = ST_IDLE;
                else if (w_expired) w_state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)           w_state_next = ST_IDLE;
                else if (w_last_vec) w_state_next = ST_FINISH;
                else                 w_state_next = w_vec_entry;
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state       <= ST_IDLE;
            r_vec         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            // Flags are derived from the next state so they line up with it.
            r_busy  <= (w_state_next == ST_SETTLE) || (w_state_next == ST_SAMPLE);
            r_done  <= (w_state_next == ST_FINISH);

            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_vec         <= '0;
                        r_pass        <= 1'b0;
                        r_err_count   <= '0;
                        r_first_valid <= 1'b0;
                        r_first_idx   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) r_vec <= '0;
                end
                ST_SAMPLE: begin
                    // Abort wins: the sample taken this cycle is discarded.
                    if (abort) begin
                        r_vec <= '0;
                    end else begin
                        if (w_mismatch) begin
                            r_err_count <= w_err_after;
                            if (!r_first_valid) begin
                                r_first_valid <= 1'b1;
                                r_first_idx   <= r_vec;
                            end
                        end
                        // pass is settled here so it is valid in the done cycle.
                        if (w_last_vec) r_pass <= (w_err_after == '0);
                        else            r_vec  <= r_vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec_out         = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_idx   = r_first_idx;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//   Directed bench: one sweeper with SETTLE=1 driving a selectable AND / OR /
//   AND-with-X-at-3 circuit, and one with SETTLE=0 driving an AND circuit.
//   Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    typedef enum int {M_AND, M_OR, M_X3} circ_e;

    logic       clk;
    logic       areset_n;
    logic       start, abort;
    logic [1:0] vec;
    logic       dut_q;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic       fev;
    logic [1:0] fidx;
    circ_e      mode;

    logic       start_z;
    logic       abort_z;
    logic [1:0] vec_z;
    logic       dut_q_z;
    logic       busy_z, done_z, pass_z;
    logic [2:0] err_count_z;
    logic       fev_z;
    logic [1:0] fidx_z;

    int n_checks;
    int n_errors;

    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXP_TT(4'b1000)) u_dut (
        .clk             (clk),
        .areset_n        (areset_n),
        .start           (start),
        .abort           (abort),
        .vec_out         (vec),
        .dut_q           (dut_q),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (fev),
        .first_err_idx   (fidx)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(0), .EXP_TT(4'b1000)) u_dut_z (
        .clk             (clk),
        .areset_n        (areset_n),
        .start           (start_z),
        .abort           (abort_z),
        .vec_out         (vec_z),
        .dut_q           (dut_q_z),
        .busy            (busy_z),
        .done            (done_z),
        .pass            (pass_z),
        .err_count       (err_count_z),
        .first_err_valid (fev_z),
        .first_err_idx   (fidx_z)
    );

    // Circuits under test.
    assign dut_q = (mode == M_OR) ? (vec[0] | vec[1]) :
                   ((mode == M_X3) && (vec == 2'd3)) ? 1'bx :
                   (vec[0] & vec[1]);
    assign dut_q_z = vec_z[0] & vec_z[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns in cycle 1 (first cycle after start was sampled).
    task automatic start_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in cycle 1; returns in the done cycle (or after the bound expires).
    task automatic run_to_done(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;

        n_checks = 0;
        n_errors = 0;
        areset_n = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        start_z  = 1'b0;
        abort_z  = 1'b0;
        mode     = M_AND;

        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_vec",   32'(vec),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_pass",  32'(pass),      32'd0);
        check("rst_err",   32'(err_count), 32'd0);
        check("rst_fev",   32'(fev),       32'd0);
        check("rst_fidx",  32'(fidx),      32'd0);

        // start together with abort in IDLE: stays idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);

        // Correct AND circuit; a start pulse in cycle 4 must be ignored.
        mode = M_AND;
        start_sweep();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) begin
                check("and_vec",  32'(vec),  32'((k - 1) / 2));
                check("and_busy", 32'(busy), 32'd1);
            end
            check("and_done", 32'(done), 32'(k == 9));
            start = (k == 4);
            if (k < 9) @(negedge clk);
        end
        check("and_pass",     32'(pass),      32'd1);
        check("and_err",      32'(err_count), 32'd0);
        check("and_fev",      32'(fev),       32'd0);
        check("and_busy_end", 32'(busy),      32'd0);
        @(negedge clk);
        check("and_done_pulse", 32'(done), 32'd0);
        check("and_pass_hold",  32'(pass), 32'd1);

        // Wrong circuit: OR mismatches at vectors 1 and 2.
        mode = M_OR;
        start_sweep();
        run_to_done("or", cyc);
        check("or_done_cyc", 32'(cyc),       32'd9);
        check("or_err",      32'(err_count), 32'd2);
        check("or_fidx",     32'(fidx),      32'd1);
        check("or_fev",      32'(fev),       32'd1);
        check("or_pass",     32'(pass),      32'd0);

        // Unknown output at vector 3.
        mode = M_X3;
        start_sweep();
        run_to_done("x3", cyc);
        check("x3_err",  32'(err_count), 32'd1);
        check("x3_fidx", 32'(fidx),      32'd3);
        check("x3_pass", 32'(pass),      32'd0);

        // Zero settle: one vector per cycle, done at cycle 5.
        @(negedge clk);
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) check("z_vec", 32'(vec_z), 32'(k - 1));
            check("z_done", 32'(done_z), 32'(k == 5));
            if (k < 5) @(negedge clk);
        end
        check("z_pass", 32'(pass_z), 32'd1);

        // Abort in the SAMPLE cycle of vector 2 (cycle 6) with the OR circuit.
        mode = M_OR;
        start_sweep();
        repeat (5) @(negedge clk);
        check("ab_vec_pre", 32'(vec),       32'd2);
        check("ab_err_pre", 32'(err_count), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", 32'(busy),      32'd0);
        check("ab_vec",  32'(vec),       32'd0);
        check("ab_done", 32'(done),      32'd0);
        check("ab_err",  32'(err_count), 32'd1);
        check("ab_fidx", 32'(fidx),      32'd1);
        check("ab_pass", 32'(pass),      32'd0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("ab_no_done", 32'(saw_done), 32'd0);

        // Fresh start after abort clears counters and completes.
        mode = M_AND;
        start_sweep();
        check("re_err_clr", 32'(err_count), 32'd0);
        check("re_fev_clr", 32'(fev),       32'd0);
        run_to_done("re", cyc);
        check("re_done_cyc", 32'(cyc),  32'd9);
        check("re_pass",     32'(pass), 32'd1);

        // Reset mid-sweep while vec_out = 1.
        mode = M_OR;
        start_sweep();
        repeat (3) @(negedge clk);
        check("mr_vec_pre",  32'(vec),  32'd1);
        check("mr_busy_pre", 32'(busy), 32'd1);
        #2 areset_n = 1'b0;
        #1;
        check("mr_vec",  32'(vec),       32'd0);
        check("mr_busy", 32'(busy),      32'd0);
        check("mr_done", 32'(done),      32'd0);
        check("mr_pass", 32'(pass),      32'd0);
        check("mr_err",  32'(err_count), 32'd0);
        check("mr_fev",  32'(fev),       32'd0);
        check("mr_fidx", 32'(fidx),      32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_done |= done | busy;
        end
        check("mr_stays_idle", 32'(saw_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
